control_sequencer: RTL and testbench

- Hardwired control unit driving the bus datapath's control inputs, one stage upstream of the datapath.
- Sequences instruction fetch (T0–T2), then decode and execute (T3–T6) for register-register ALU, MUL/DIV, unary and HALT instructions.
- Reads the instruction from the datapath IR.
- Replaces hand-driven testbench control with a Moore state machine.

---
 rtl/cpu_ctrl_pkg.sv | 77 +++++++
 rtl/reg_field_decoder.sv | 17 +
 rtl/control_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, datapath
// strobe bit positions, state encodings and the opcode classifier.
package cpu_ctrl_pkg;

    // Opcode field width, IR[31:27]
    localparam int OP_W = 5;

    // Opcodes
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b01001;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01010;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    // Bit positions inside the 16-bit ctl strobe vector
    localparam int CTL_PCOUT   = 0;
    localparam int CTL_PCIN    = 1;
    localparam int CTL_INCPC   = 2;
    localparam int CTL_MARIN   = 3;
    localparam int CTL_READ    = 4;
    localparam int CTL_MDRIN   = 5;
    localparam int CTL_MDROUT  = 6;
    localparam int CTL_IRIN    = 7;
    localparam int CTL_YIN     = 8;
    localparam int CTL_ZLOWIN  = 9;
    localparam int CTL_ZHIGHIN = 10;
    localparam int CTL_ZLOOUT  = 11;
    localparam int CTL_ZHIOUT  = 12;
    localparam int CTL_HIIN    = 13;
    localparam int CTL_LOIN    = 14;
    localparam int CTL_SPARE   = 15;

    // Sequencer states; the encoding is visible on state_dbg
    typedef enum logic [3:0] {
        RESET = 4'd0,
        T0    = 4'd1,
        T1    = 4'd2,
        T2    = 4'd3,
        T3    = 4'd4,
        T4    = 4'd5,
        T5    = 4'd6,
        T6    = 4'd7,
        HALT  = 4'd8
    } state_t;

    // Instruction classes that select the T3..T6 strobe pattern
    typedef enum logic [2:0] {
        CLS_BINARY  = 3'd0,
        CLS_UNARY   = 3'd1,
        CLS_MULDIV  = 3'd2,
        CLS_HALT    = 3'd3,
        CLS_ILLEGAL = 3'd4
    } op_class_t;

    // Map an opcode onto its instruction class; anything unlisted is illegal
    function automatic op_class_t classify(input logic [OP_W-1:0] op);
        op_class_t cls;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = CLS_BINARY;
            OP_NEG, OP_NOT:                 cls = CLS_UNARY;
            OP_MUL, OP_DIV:                 cls = CLS_MULDIV;
            OP_HALT:                        cls = CLS_HALT;
            default:                        cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/reg_field_decoder.sv
// Turns a 4-bit register field into a 16-bit one-hot select, gated by an
// enable so that an idle path drives no register at all.
module reg_field_decoder (
    input  logic [3:0]  field,
    input  logic        en,
    output logic [15:0] onehot
);

    // One-hot decode of the register number when enabled
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[field] = 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the bus datapath. Sequences fetch (T0..T2)
// and decode/execute (T3..T6) for register-register ALU, unary, MUL/DIV and
// HALT instructions. Outputs are decoded combinationally from the state
// register, the IR and the read-wait counter; the datapath samples them on
// the next rising clock edge.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int READ_WAIT = 0,   // extra memory wait cycles in T1, 0..15
    parameter int OPW       = 5    // opcode width, IR[31:27]
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [31:0]     IR,
    input  logic            stop,
    output logic [15:0]     ctl,
    output logic [15:0]     Rin,
    output logic [15:0]     Rout,
    output logic [OPW-1:0]  operation,
    output logic            run,
    output logic            illegal,
    output logic [3:0]      state_dbg
);

    // Last T1 count value; T1 lasts WAIT_LAST+1 cycles
    localparam logic [3:0] WAIT_LAST = 4'(READ_WAIT);

    // IR fields
    logic [OPW-1:0] op;
    logic [3:0]     ra;
    logic [3:0]     rb;
    logic [3:0]     rc;
    op_class_t      cls;

    assign op  = IR[31 -: OPW];
    assign ra  = IR[26:23];
    assign rb  = IR[22:19];
    assign rc  = IR[18:15];
    assign cls = classify(op);

    // Immediate/unused low IR bits are not needed by this control unit
    logic unused_ir_bits;
    assign unused_ir_bits = ^IR[14:0];

    // Sequencer state and T1 wait counter
    state_t     state_q;
    logic [3:0] wait_q;
    logic       t1_last;
    state_t     end_next;

    // Final T1 cycle: memory data is ready and PC may be updated once
    assign t1_last  = (wait_q == WAIT_LAST);
    // Where an instruction goes when it completes; stop only matters here
    assign end_next = stop ? HALT : T0;

    // Next-state sequencing with asynchronous clear
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= RESET;
            wait_q  <= '0;
        end else begin
            case (state_q)
                RESET: state_q <= T0;
                T0:    state_q <= T1;
                T1: begin
                    if (t1_last) begin
                        wait_q  <= '0;
                        state_q <= T2;
                    end else begin
                        wait_q  <= wait_q + 4'd1;
                    end
                end
                T2:    state_q <= T3;
                T3: begin
                    case (cls)
                        CLS_ILLEGAL: state_q <= T0;
                        CLS_HALT:    state_q <= HALT;
                        default:     state_q <= T4;
                    endcase
                end
                T4:    state_q <= T5;
                T5: begin
                    if (cls == CLS_MULDIV) begin
                        state_q <= T6;
                    end else begin
                        state_q <= end_next;
                    end
                end
                T6:    state_q <= end_next;
                HALT:  state_q <= HALT;
                default: begin
                    state_q <= RESET;
                    wait_q  <= '0;
                end
            endcase
        end
    end

    // Register-select requests handed to the two field decoders
    logic       rin_en;
    logic [3:0] rin_field;
    logic       rout_en;
    logic [3:0] rout_field;

    // Strobe decode from state, opcode class and wait counter
    always_comb begin
        ctl        = '0;
        rin_en     = 1'b0;
        rin_field  = ra;
        rout_en    = 1'b0;
        rout_field = rb;
        operation  = '0;
        illegal    = 1'b0;
        case (state_q)
            T0: begin
                ctl[CTL_PCOUT]  = 1'b1;
                ctl[CTL_MARIN]  = 1'b1;
                ctl[CTL_INCPC]  = 1'b1;
                ctl[CTL_ZLOWIN] = 1'b1;
            end
            T1: begin
                ctl[CTL_READ]  = 1'b1;
                ctl[CTL_MDRIN] = 1'b1;
                if (t1_last) begin
                    ctl[CTL_ZLOOUT] = 1'b1;
                    ctl[CTL_PCIN]   = 1'b1;
                end
            end
            T2: begin
                ctl[CTL_MDROUT] = 1'b1;
                ctl[CTL_IRIN]   = 1'b1;
            end
            T3: begin
                case (cls)
                    CLS_BINARY, CLS_UNARY: begin
                        rout_en      = 1'b1;
                        rout_field   = rb;
                        ctl[CTL_YIN] = 1'b1;
                    end
                    CLS_MULDIV: begin
                        rout_en      = 1'b1;
                        rout_field   = ra;
                        ctl[CTL_YIN] = 1'b1;
                    end
                    CLS_ILLEGAL: illegal = 1'b1;
                    default: ;
                endcase
            end
            T4: begin
                case (cls)
                    CLS_BINARY: begin
                        rout_en         = 1'b1;
                        rout_field      = rc;
                        ctl[CTL_ZLOWIN] = 1'b1;
                        operation       = op;
                    end
                    CLS_UNARY: begin
                        rout_en         = 1'b1;
                        rout_field      = rb;
                        ctl[CTL_ZLOWIN] = 1'b1;
                        operation       = op;
                    end
                    CLS_MULDIV: begin
                        rout_en          = 1'b1;
                        rout_field       = rb;
                        ctl[CTL_ZLOWIN]  = 1'b1;
                        ctl[CTL_ZHIGHIN] = 1'b1;
                        operation        = op;
                    end
                    default: ;
                endcase
            end
            T5: begin
                ctl[CTL_ZLOOUT] = 1'b1;
                if (cls == CLS_MULDIV) begin
                    ctl[CTL_LOIN] = 1'b1;
                end else begin
                    // R0 as destination is still strobed; the datapath owns R0
                    rin_en    = 1'b1;
                    rin_field = ra;
                end
            end
            T6: begin
                ctl[CTL_ZHIOUT] = 1'b1;
                ctl[CTL_HIIN]   = 1'b1;
            end
            default: ;
        endcase
    end

    reg_field_decoder u_rin_dec (
        .field  (rin_field),
        .en     (rin_en),
        .onehot (Rin)
    );

    reg_field_decoder u_rout_dec (
        .field  (rout_field),
        .en     (rout_en),
        .onehot (Rout)
    );

    assign run       = (state_q != RESET) && (state_q != HALT);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer. A tiny datapath stand-in (register
// file, Y and Z registers, OR-only ALU) follows the strobes so the OR
// instruction result can be observed; a second instance runs with
// READ_WAIT=2 for the wait-state sequence.
module tb_control_sequencer;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        clear, clear_w;
    logic [31:0] IR, IR_w;
    logic        stop, stop_w;

    logic [15:0] ctl, Rin, Rout;
    logic [4:0]  operation;
    logic        run, illegal;
    logic [3:0]  state_dbg;

    logic [15:0] ctl_w, Rin_w, Rout_w;
    logic [4:0]  operation_w;
    logic        run_w, illegal_w;
    logic [3:0]  state_dbg_w;

    control_sequencer #(.READ_WAIT(0), .OPW(5)) dut (
        .clock(clock), .clear(clear), .IR(IR), .stop(stop),
        .ctl(ctl), .Rin(Rin), .Rout(Rout), .operation(operation),
        .run(run), .illegal(illegal), .state_dbg(state_dbg)
    );

    control_sequencer #(.READ_WAIT(2), .OPW(5)) dut_w (
        .clock(clock), .clear(clear_w), .IR(IR_w), .stop(stop_w),
        .ctl(ctl_w), .Rin(Rin_w), .Rout(Rout_w), .operation(operation_w),
        .run(run_w), .illegal(illegal_w), .state_dbg(state_dbg_w)
    );

    // Hand-encoded instructions
    localparam logic [31:0] IR_OR   = 32'h3091_8000;            // OR R1,R2,R3
    localparam logic [31:0] IR_MUL  = {5'b01111, 4'd4, 4'd5, 19'd0};
    localparam logic [31:0] IR_BAD  = {5'b11111, 27'd0};
    localparam logic [31:0] IR_HALT = {5'b11011, 27'd0};

    // Hand-computed strobe masks (bit 0 PCout ... bit 14 LOin)
    localparam logic [31:0] M_T0      = 32'h020D;
    localparam logic [31:0] M_T1_WAIT = 32'h0030;
    localparam logic [31:0] M_T1_LAST = 32'h0832;
    localparam logic [31:0] M_T2      = 32'h00C0;
    localparam logic [31:0] M_YIN     = 32'h0100;
    localparam logic [31:0] M_ZLOWIN  = 32'h0200;
    localparam logic [31:0] M_ZBOTH   = 32'h0600;
    localparam logic [31:0] M_ZLOOUT  = 32'h0800;
    localparam logic [31:0] M_T5_MD   = 32'h4800;
    localparam logic [31:0] M_T6_MD   = 32'h3000;

    // ---------------- datapath stand-in ----------------
    logic        dp_load;
    logic [31:0] regs [16];
    logic [31:0] y_q, z_lo, bus;

    always_comb begin
        bus = '0;
        for (int i = 0; i < 16; i++) begin
            if (Rout[i]) bus = regs[i];
        end
        if (ctl[11]) bus = z_lo;
    end

    always @(posedge clock) begin
        if (dp_load) begin
            for (int i = 0; i < 16; i++) regs[i] <= 32'h0;
            regs[2] <= 32'h12;
            regs[3] <= 32'h14;
            y_q     <= 32'h0;
            z_lo    <= 32'h0;
        end else begin
            if (ctl[8]) y_q <= bus;
            if (ctl[9]) z_lo <= (operation == 5'b00110) ? (y_q | bus) : 32'h0;
            for (int i = 0; i < 16; i++) begin
                if (Rin[i]) regs[i] <= bus;
            end
        end
    end

    // Count cycles with more than one bus driver
    int bus_conflicts = 0;
    always @(negedge clock) begin
        if ($countones(Rout) + 32'(ctl[0]) + 32'(ctl[6]) + 32'(ctl[11]) + 32'(ctl[12]) > 1)
            bus_conflicts <= bus_conflicts + 1;
    end

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle away from the edge
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    int not_halt;

    // ---------------- directed sequence ----------------
    initial begin
        clear = 1'b1; clear_w = 1'b1; dp_load = 1'b1;
        IR = IR_OR; IR_w = IR_OR; stop = 1'b0; stop_w = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_state", 32'(state_dbg), 32'd0);
        chk("rst_run",   32'(run), 32'd0);
        chk("rst_ctl",   32'(ctl), 32'h0);
        chk("rst_rin",   32'(Rin), 32'h0);
        chk("rst_rout",  32'(Rout), 32'h0);
        chk("rst_op",    32'(operation), 32'h0);
        clear = 1'b0; dp_load = 1'b0;
        #1;
        chk("rel_state", 32'(state_dbg), 32'd0);
        chk("rel_run",   32'(run), 32'd0);

        // Fetch of OR R1,R2,R3
        tick();
        chk("t0_state", 32'(state_dbg), 32'd1);
        chk("t0_ctl",   32'(ctl), M_T0);
        chk("t0_run",   32'(run), 32'd1);
        tick();
        chk("t1_ctl",   32'(ctl), M_T1_LAST);
        tick();
        chk("t2_ctl",   32'(ctl), M_T2);
        chk("t2_ill",   32'(illegal), 32'd0);

        // Execute OR
        tick();
        chk("or_t3_rout", 32'(Rout), 32'h0004);
        chk("or_t3_ctl",  32'(ctl), M_YIN);
        tick();
        chk("or_t4_rout", 32'(Rout), 32'h0008);
        chk("or_t4_op",   32'(operation), 32'h06);
        chk("or_t4_ctl",  32'(ctl), M_ZLOWIN);
        tick();
        chk("or_t5_ctl",  32'(ctl), M_ZLOOUT);
        chk("or_t5_rin",  32'(Rin), 32'h0002);
        chk("or_t5_rout", 32'(Rout), 32'h0);
        chk("or_t5_op",   32'(operation), 32'h0);
        tick();
        chk("or_next_t0", 32'(state_dbg), 32'd1);
        chk("or_r1",      regs[1], 32'h16);

        // MUL R4,R5
        IR = IR_MUL;
        tick(); tick(); tick();
        chk("mul_t3_rout", 32'(Rout), 32'h0010);
        chk("mul_t3_ctl",  32'(ctl), M_YIN);
        tick();
        chk("mul_t4_rout", 32'(Rout), 32'h0020);
        chk("mul_t4_ctl",  32'(ctl), M_ZBOTH);
        chk("mul_t4_op",   32'(operation), 32'h0F);
        tick();
        chk("mul_t5_ctl",  32'(ctl), M_T5_MD);
        chk("mul_t5_rin",  32'(Rin), 32'h0);
        tick();
        chk("mul_t6_state", 32'(state_dbg), 32'd7);
        chk("mul_t6_ctl",   32'(ctl), M_T6_MD);
        tick();
        chk("mul_next_t0",  32'(state_dbg), 32'd1);

        // Undefined opcode
        IR = IR_BAD;
        tick(); tick(); tick();
        chk("bad_t3_ill",  32'(illegal), 32'd1);
        chk("bad_t3_ctl",  32'(ctl), 32'h0);
        chk("bad_t3_rout", 32'(Rout), 32'h0);
        tick();
        chk("bad_next_t0", 32'(state_dbg), 32'd1);
        chk("bad_ill_off", 32'(illegal), 32'd0);

        // stop raised during T4 of an ALU op ends in HALT after T5
        IR = IR_OR;
        tick(); tick(); tick(); tick();
        chk("stop_t4", 32'(state_dbg), 32'd5);
        stop = 1'b1;
        tick();
        chk("stop_t5_state", 32'(state_dbg), 32'd6);
        chk("stop_t5_ctl",   32'(ctl), M_ZLOOUT);
        tick();
        chk("stop_halt", 32'(state_dbg), 32'd8);
        chk("stop_run",  32'(run), 32'd0);
        chk("stop_ctl",  32'(ctl), 32'h0);
        stop = 1'b0;
        not_halt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (state_dbg !== 4'd8) not_halt++;
        end
        chk("stop_halt_hold", 32'(not_halt), 32'd0);

        // Only clear leaves HALT; then a HALT instruction
        clear = 1'b1;
        #1;
        chk("halt_clear", 32'(state_dbg), 32'd0);
        tick();
        clear = 1'b0;
        IR = IR_HALT;
        tick();
        chk("hlt_t0", 32'(state_dbg), 32'd1);
        tick(); tick(); tick();
        chk("hlt_t3_state", 32'(state_dbg), 32'd4);
        chk("hlt_t3_ctl",   32'(ctl), 32'h0);
        chk("hlt_t3_ill",   32'(illegal), 32'd0);
        tick();
        chk("hlt_state", 32'(state_dbg), 32'd8);
        chk("hlt_run",   32'(run), 32'd0);
        not_halt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (state_dbg !== 4'd8 || run !== 1'b0) not_halt++;
        end
        chk("hlt_hold", 32'(not_halt), 32'd0);

        // Asynchronous clear in the middle of T4
        clear = 1'b1;
        #1;
        clear = 1'b0;
        IR = IR_OR;
        tick();
        chk("async_t0", 32'(state_dbg), 32'd1);
        tick(); tick(); tick(); tick();
        chk("async_pre_op", 32'(operation), 32'h06);
        #2;
        clear = 1'b1;
        #1;
        chk("async_state", 32'(state_dbg), 32'd0);
        chk("async_ctl",   32'(ctl), 32'h0);
        chk("async_rout",  32'(Rout), 32'h0);
        chk("async_op",    32'(operation), 32'h0);
        chk("async_run",   32'(run), 32'd0);
        tick();
        clear = 1'b0;
        tick();
        chk("async_rel_t0", 32'(state_dbg), 32'd1);

        // READ_WAIT=2 instance: T1 lasts three cycles, PCin only in the last
        clear_w = 1'b0;
        tick();
        chk("w_t0", 32'(state_dbg_w), 32'd1);
        tick();
        chk("w_t1a_state", 32'(state_dbg_w), 32'd2);
        chk("w_t1a_ctl",   32'(ctl_w), M_T1_WAIT);
        tick();
        chk("w_t1b_state", 32'(state_dbg_w), 32'd2);
        chk("w_t1b_ctl",   32'(ctl_w), M_T1_WAIT);
        tick();
        chk("w_t1c_state", 32'(state_dbg_w), 32'd2);
        chk("w_t1c_ctl",   32'(ctl_w), M_T1_LAST);
        tick();
        chk("w_t2_state", 32'(state_dbg_w), 32'd3);
        chk("w_t2_ctl",   32'(ctl_w), M_T2);

        chk("bus_conflicts", 32'(bus_conflicts), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
